// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results, with a destination scoreboard for decode hazards.
// Latency: pipeline writes go out in the request cycle; long-latency results no earlier than the cycle after enqueue.
// Backpressure: ll_ready_o drops while the FIFO is full; pipe_stall_o holds the pipeline while a starved FIFO head is forced through.
module rf_wb_arbiter #(
    parameter int REG_SIZE     = 32,
    parameter int REGW         = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pipe_valid_i,
    input  logic [REGW-1:0]     pipe_waddr_i,
    input  logic [REG_SIZE-1:0] pipe_wdata_i,
    output logic                pipe_stall_o,
    input  logic                ll_valid_i,
    output logic                ll_ready_o,
    input  logic [REGW-1:0]     ll_waddr_i,
    input  logic [REG_SIZE-1:0] ll_wdata_i,
    input  logic                ll_issue_i,
    input  logic [REGW-1:0]     ll_issue_rd_i,
    input  logic [REGW-1:0]     rs1_i,
    input  logic [REGW-1:0]     rs2_i,
    output logic                hazard_o,
    output logic                rf_we_o,
    output logic [REGW-1:0]     rf_waddr_o,
    output logic [REG_SIZE-1:0] rf_wdata_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 1 << REGW;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  LIMIT    = SC_W'(STARVE_LIMIT);

    logic [REGW-1:0]     addr_mem [FIFO_DEPTH];
    logic [REG_SIZE-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [SC_W-1:0]     starve_cnt;
    logic [NREG-1:0]     pending;

    logic                empty;
    logic                full;
    logic                force_head;
    logic                grant_pipe;
    logic                grant_fifo;
    logic                push;
    logic                pop;
    logic [REGW-1:0]     head_addr;
    logic [REG_SIZE-1:0] head_data;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];

    // Full blocks enqueue even when the head drains this cycle: no pass-through.
    assign ll_ready_o = !full;
    assign push       = ll_valid_i && !full;

    assign force_head   = !empty && (starve_cnt == LIMIT);
    assign pipe_stall_o = force_head && pipe_valid_i;
    assign grant_pipe   = rst_ni && pipe_valid_i && !force_head;
    assign grant_fifo   = !grant_pipe && !empty;
    assign pop          = grant_fifo;

    always_comb begin
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (grant_pipe) begin
            rf_waddr_o = pipe_waddr_i;
            rf_wdata_o = pipe_wdata_i;
        end else if (grant_fifo) begin
            rf_waddr_o = head_addr;
            rf_wdata_o = head_data;
        end
    end

    // x0 grants still consume the slot (and pop the FIFO) but never write.
    assign rf_we_o = (grant_pipe || grant_fifo) && (rf_waddr_o != '0);

    assign hazard_o = ((rs1_i != '0) && pending[rs1_i]) ||
                      ((rs2_i != '0) && pending[rs2_i]);

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr] <= ll_waddr_i;
            data_mem[wr_ptr] <= ll_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (grant_pipe && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A new issue to the same register outranks the retiring entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (ll_issue_i && (ll_issue_rd_i == REGW'(i))) begin
                    pending[i] <= 1'b1;
                end else if (pop && (head_addr == REGW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
            pending[0] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand-written corner sequences, then random traffic against a queue-based model.
module tb_rf_wb_arbiter;

    localparam int REG_SIZE     = 32;
    localparam int REGW         = 5;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int NVEC         = 22;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                pipe_valid_i;
    logic [REGW-1:0]     pipe_waddr_i;
    logic [REG_SIZE-1:0] pipe_wdata_i;
    logic                pipe_stall_o;
    logic                ll_valid_i;
    logic                ll_ready_o;
    logic [REGW-1:0]     ll_waddr_i;
    logic [REG_SIZE-1:0] ll_wdata_i;
    logic                ll_issue_i;
    logic [REGW-1:0]     ll_issue_rd_i;
    logic [REGW-1:0]     rs1_i;
    logic [REGW-1:0]     rs2_i;
    logic                hazard_o;
    logic                rf_we_o;
    logic [REGW-1:0]     rf_waddr_o;
    logic [REG_SIZE-1:0] rf_wdata_o;

    always #5 clk_i = ~clk_i;

    rf_wb_arbiter #(
        .REG_SIZE(REG_SIZE), .REGW(REGW), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pipe_valid_i(pipe_valid_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .pipe_stall_o(pipe_stall_o),
        .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o), .ll_waddr_i(ll_waddr_i), .ll_wdata_i(ll_wdata_i),
        .ll_issue_i(ll_issue_i), .ll_issue_rd_i(ll_issue_rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        pipe_valid_i  = 1'b0;
        pipe_waddr_i  = '0;
        pipe_wdata_i  = '0;
        ll_valid_i    = 1'b0;
        ll_waddr_i    = '0;
        ll_wdata_i    = '0;
        ll_issue_i    = 1'b0;
        ll_issue_rd_i = '0;
        rs1_i         = '0;
        rs2_i         = '0;
    endtask

    task automatic next_cyc();
        @(negedge clk_i);
        clr_in();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        iss;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic        rdy;
        logic        hz;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic iss, input logic [4:0] ird, input logic [4:0] rs1,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic st, input logic rdy, input logic hz);
        vec_t v;
        v.pv = pv; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld;
        v.iss = iss; v.ird = ird; v.rs1 = rs1;
        v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.rdy = rdy; v.hz = hz;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [REGW-1:0]     a;
        logic [REG_SIZE-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   m_starve;
    bit   m_pend [32];
    bit   m_stall;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_check(input int n);
        bit                  rdy, frc, gp, gf, we, hz;
        logic [REGW-1:0]     wa;
        logic [REG_SIZE-1:0] wd;
        ent_t                e;
        rdy = (mq.size() < FIFO_DEPTH);
        frc = (mq.size() != 0) && (m_starve == STARVE_LIMIT);
        gp  = pipe_valid_i && !frc;
        gf  = !gp && (mq.size() != 0);
        wa  = gp ? pipe_waddr_i : (gf ? mq[0].a : '0);
        wd  = gp ? pipe_wdata_i : (gf ? mq[0].d : '0);
        we  = (gp || gf) && (wa != 0);
        hz  = (rs1_i != 0 && m_pend[rs1_i]) || (rs2_i != 0 && m_pend[rs2_i]);
        m_stall = frc && pipe_valid_i;

        chk($sformatf("rnd%0d_we", n), rf_we_o, we);
        if (we) begin
            chk($sformatf("rnd%0d_waddr", n), rf_waddr_o, wa);
            chk($sformatf("rnd%0d_wdata", n), rf_wdata_o, wd);
        end
        chk($sformatf("rnd%0d_stall", n), pipe_stall_o, m_stall);
        chk($sformatf("rnd%0d_ready", n), ll_ready_o, rdy);
        chk($sformatf("rnd%0d_hazard", n), hazard_o, hz);

        if (gf) begin
            m_pend[mq[0].a] = 1'b0;
            void'(mq.pop_front());
            m_starve = 0;
        end else if (mq.size() == 0) begin
            m_starve = 0;
        end else if (gp && m_starve < STARVE_LIMIT) begin
            m_starve++;
        end
        if (ll_issue_i && ll_issue_rd_i != 0) m_pend[ll_issue_rd_i] = 1'b1;
        if (ll_valid_i && rdy) begin
            e.a = ll_waddr_i;
            e.d = ll_wdata_i;
            mq.push_back(e);
        end
    endtask

    initial begin
        bit hold;

        tbl[0]  = mk(0, 0, 0,        1, 7, 32'hDEADBEEF, 0, 0, 0,  0, 0, 0,            0, 1, 0);
        tbl[1]  = mk(0, 0, 0,        0, 0, 0,            0, 0, 0,  1, 7, 32'hDEADBEEF, 0, 1, 0);
        tbl[2]  = mk(1, 1, 32'h11,   1, 3, 32'h33333333, 1, 3, 3,  1, 1, 32'h11,       0, 1, 0);
        tbl[3]  = mk(1, 2, 32'h22,   0, 0, 0,            0, 0, 3,  1, 2, 32'h22,       0, 1, 1);
        tbl[4]  = mk(1, 4, 32'h44,   0, 0, 0,            0, 0, 3,  1, 4, 32'h44,       0, 1, 1);
        tbl[5]  = mk(1, 5, 32'h55,   0, 0, 0,            0, 0, 3,  1, 5, 32'h55,       0, 1, 1);
        tbl[6]  = mk(1, 6, 32'h66,   0, 0, 0,            0, 0, 3,  1, 6, 32'h66,       0, 1, 1);
        tbl[7]  = mk(1, 8, 32'h88,   0, 0, 0,            0, 0, 3,  1, 3, 32'h33333333, 1, 1, 1);
        tbl[8]  = mk(1, 8, 32'h88,   0, 0, 0,            0, 0, 3,  1, 8, 32'h88,       0, 1, 0);
        tbl[9]  = mk(1, 10, 32'hA0,  1, 0, 32'hAA,       0, 0, 3,  1, 10, 32'hA0,      0, 1, 0);
        tbl[10] = mk(1, 11, 32'hB0,  1, 12, 32'hCC,      0, 0, 0,  1, 11, 32'hB0,      0, 1, 0);
        tbl[11] = mk(1, 13, 32'hD0,  1, 22, 32'h2222,    0, 0, 0,  1, 13, 32'hD0,      0, 0, 0);
        tbl[12] = mk(1, 14, 32'hE0,  0, 0, 0,            0, 0, 0,  1, 14, 32'hE0,      0, 0, 0);
        tbl[13] = mk(1, 15, 32'hF0,  0, 0, 0,            0, 0, 0,  1, 15, 32'hF0,      0, 0, 0);
        tbl[14] = mk(1, 16, 32'h16,  1, 21, 32'h2121,    0, 0, 0,  0, 0, 0,            1, 0, 0);
        tbl[15] = mk(1, 16, 32'h16,  0, 0, 0,            0, 0, 0,  1, 16, 32'h16,      0, 1, 0);
        tbl[16] = mk(1, 17, 32'h17,  0, 0, 0,            0, 0, 0,  1, 17, 32'h17,      0, 1, 0);
        tbl[17] = mk(1, 18, 32'h18,  0, 0, 0,            0, 0, 0,  1, 18, 32'h18,      0, 1, 0);
        tbl[18] = mk(1, 19, 32'h19,  0, 0, 0,            0, 0, 0,  1, 19, 32'h19,      0, 1, 0);
        tbl[19] = mk(1, 20, 32'h20,  0, 0, 0,            0, 0, 0,  1, 12, 32'hCC,      1, 1, 0);
        tbl[20] = mk(1, 20, 32'h20,  0, 0, 0,            0, 0, 0,  1, 20, 32'h20,      0, 1, 0);
        tbl[21] = mk(0, 0, 0,        0, 0, 0,            0, 0, 0,  0, 0, 0,            0, 1, 0);

        clr_in();
        rst_ni = 1'b0;
        #1;
        chk("reset_we", rf_we_o, 1'b0);
        chk("reset_stall", pipe_stall_o, 1'b0);
        chk("reset_hazard", hazard_o, 1'b0);
        chk("reset_ready", ll_ready_o, 1'b1);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // idle drain, starvation, x0 entry, full FIFO rejecting a third push
        for (int k = 0; k < NVEC; k++) begin
            next_cyc();
            pipe_valid_i  = tbl[k].pv;
            pipe_waddr_i  = tbl[k].pa;
            pipe_wdata_i  = tbl[k].pd;
            ll_valid_i    = tbl[k].lv;
            ll_waddr_i    = tbl[k].la;
            ll_wdata_i    = tbl[k].ld;
            ll_issue_i    = tbl[k].iss;
            ll_issue_rd_i = tbl[k].ird;
            rs1_i         = tbl[k].rs1;
            #1;
            chk($sformatf("tbl%0d_we", k), rf_we_o, tbl[k].we);
            if (tbl[k].we) begin
                chk($sformatf("tbl%0d_waddr", k), rf_waddr_o, tbl[k].wa);
                chk($sformatf("tbl%0d_wdata", k), rf_wdata_o, tbl[k].wd);
            end
            chk($sformatf("tbl%0d_stall", k), pipe_stall_o, tbl[k].st);
            chk($sformatf("tbl%0d_ready", k), ll_ready_o, tbl[k].rdy);
            chk($sformatf("tbl%0d_hazard", k), hazard_o, tbl[k].hz);
        end

        // scoreboard: same-cycle invisibility, rs2 path, set-wins on pop cycle
        next_cyc(); ll_issue_i = 1; ll_issue_rd_i = 9; rs1_i = 9;
        #1 chk("sb_same_cycle", hazard_o, 1'b0);
        next_cyc(); ll_issue_i = 1; ll_issue_rd_i = 0; rs1_i = 9;
        ll_valid_i = 1; ll_waddr_i = 9; ll_wdata_i = 32'h99; pipe_valid_i = 1; pipe_waddr_i = 1;
        #1 chk("sb_set", hazard_o, 1'b1);
        next_cyc(); pipe_valid_i = 1; pipe_waddr_i = 2; rs2_i = 9;
        #1 chk("sb_rs2", hazard_o, 1'b1);
        chk("sb_pipe_waddr", rf_waddr_o, 5'd2);
        next_cyc(); ll_issue_i = 1; ll_issue_rd_i = 9; rs1_i = 9;
        #1 chk("sb_pop_we", rf_we_o, 1'b1);
        chk("sb_pop_waddr", rf_waddr_o, 5'd9);
        chk("sb_pop_wdata", rf_wdata_o, 32'h99);
        chk("sb_pop_hazard", hazard_o, 1'b1);
        next_cyc(); rs1_i = 9;
        #1 chk("sb_set_wins", hazard_o, 1'b1);
        chk("sb_idle_we", rf_we_o, 1'b0);
        next_cyc(); rs1_i = 9; ll_valid_i = 1; ll_waddr_i = 9; ll_wdata_i = 32'h98;
        #1 chk("sb_push2_hazard", hazard_o, 1'b1);
        next_cyc(); rs1_i = 9;
        #1 chk("sb_pop2_waddr", rf_waddr_o, 5'd9);
        chk("sb_pop2_wdata", rf_wdata_o, 32'h98);
        chk("sb_pop2_hazard", hazard_o, 1'b1);
        next_cyc(); rs1_i = 9;
        #1 chk("sb_cleared", hazard_o, 1'b0);

        // reset mid-stream with two queued entries and x5 pending
        next_cyc(); ll_issue_i = 1; ll_issue_rd_i = 5; ll_valid_i = 1; ll_waddr_i = 5;
        ll_wdata_i = 32'h55; pipe_valid_i = 1; pipe_waddr_i = 1;
        next_cyc(); ll_valid_i = 1; ll_waddr_i = 6; ll_wdata_i = 32'h66;
        pipe_valid_i = 1; pipe_waddr_i = 2;
        next_cyc(); pipe_valid_i = 1; pipe_waddr_i = 3; rs1_i = 5;
        #1 chk("rst_pre_ready", ll_ready_o, 1'b0);
        chk("rst_pre_hazard", hazard_o, 1'b1);
        #1 pipe_valid_i = 0; rst_ni = 1'b0;
        #1 chk("rst_mid_ready", ll_ready_o, 1'b1);
        chk("rst_mid_we", rf_we_o, 1'b0);
        chk("rst_mid_hazard", hazard_o, 1'b0);
        chk("rst_mid_stall", pipe_stall_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            next_cyc(); rs1_i = 5;
            #1 chk($sformatf("rst_post%0d_we", k), rf_we_o, 1'b0);
            chk($sformatf("rst_post%0d_hazard", k), hazard_o, 1'b0);
        end

        // random traffic against the model
        next_cyc();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk_i);
            if (!hold) begin
                pipe_valid_i = ($urandom_range(0, 9) < 7);
                pipe_waddr_i = 5'($urandom_range(0, 7));
                pipe_wdata_i = $urandom;
            end
            ll_valid_i    = ($urandom_range(0, 1) == 1);
            ll_waddr_i    = 5'($urandom_range(0, 7));
            ll_wdata_i    = $urandom;
            ll_issue_i    = ($urandom_range(0, 9) < 3);
            ll_issue_rd_i = 5'($urandom_range(0, 7));
            rs1_i         = 5'($urandom_range(0, 7));
            rs2_i         = 5'($urandom_range(0, 7));
            #1;
            model_check(n);
            hold = m_stall;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
